mem_port_master: RTL and testbench
==================================

# mem_port_master

Initiator for the single-port synchronous Memory block: accepts single or burst read/write requests from a CPU-side valid/ready handshake and drives the Memory's `rw_enable`/`address`/`data_in` port, returning read data per beat. Sits between the core's load/store path and the Memory instance. It owns the memory port exclusively and guarantees the Memory never sees a write strobe outside an accepted write beat.

## Interface
- ADDR_W, 10, address width; matches the Memory address port
- DATA_W, 16, data width
- LEN_W, 4, burst length field width; a burst is 1 to 2^LEN_W beats
- READ_LATENCY, 1, clock edges from the Memory sampling an address to `data_out` being valid; legal values 1–3
- clk  in  1  system clock, all logic on the rising edge
- rst_n  in  1  reset, asynchronous assert, active-low
- req_valid  in  1  request offered
- req_ready  out  1  request accepted when both valid and ready are high
- req_write  in  1  1 = write burst, 0 = read burst
- req_addr  in  ADDR_W  first beat address
- req_len  in  LEN_W  beats minus one
- wr_valid  in  1  write beat data offered
- wr_ready  out  1  write beat accepted
- wr_data  in  DATA_W  write beat data
- wr_done  out  1  one-cycle pulse when the last write beat commits
- rd_valid  out  1  read beat data valid
- rd_ready  in  1  consumer accepts read beat
- rd_data  out  DATA_W  read beat data
- rd_last  out  1  qualifies the final read beat
- busy  out  1  high in every state except IDLE
- mem_rw_enable  out  1  to Memory: 0 = write, 1 = read
- mem_address  out  ADDR_W  to Memory
- mem_data_in  out  DATA_W  to Memory
- mem_data_out  in  DATA_W  from Memory

## Operation
- States: IDLE, WR, RD_ISSUE, RD_RESP. All outputs are registered.
- IDLE: `req_ready=1`. On a handshake, latch `cur_addr=req_addr` and `beats=req_len`, then go to WR (`req_write=1`) or RD_ISSUE.
- WR: `wr_ready=1`. Each `wr_valid&&wr_ready` edge registers `mem_address=cur_addr`, `mem_data_in=wr_data`, `mem_rw_enable=0`. Then `cur_addr` increments and `beats` decrements.
- WR with no beat on an edge: `mem_rw_enable` returns to 1 for that cycle, so a gap in `wr_valid` produces no write.
- WR last beat: on the last-beat handshake, go to IDLE. `mem_rw_enable` is 0 for exactly that one following cycle, and `wr_done` pulses in the same cycle.
- RD_ISSUE: `mem_address=cur_addr`, `mem_rw_enable=1`. A latency counter runs READ_LATENCY+1 edges, then the FSM captures `mem_data_out` into `rd_data`, sets `rd_valid=1`, and goes to RD_RESP.
- RD_RESP: hold `rd_data`/`rd_valid`/`rd_last` stable until `rd_ready`. On that handshake, increment `cur_addr` and either return to RD_ISSUE or, if it was the last beat, go to IDLE.
- Address arithmetic: `cur_addr` increments modulo 2^ADDR_W, so 0x3FF+1 = 0x000. No error is flagged on wrap.
- `req_valid` is ignored while busy. `wr_valid` outside WR and `rd_ready` while `rd_valid=0` have no effect.
- Outside accepted write beats, `mem_rw_enable` is always 1. Idle and read cycles never write.

## Timing
- Reset values: state=IDLE, `req_ready=1` (after reset), `wr_ready=0`, `rd_valid=0`, `rd_last=0`, `rd_data=0`, `wr_done=0`, `busy=0`, `mem_rw_enable=1`, `mem_address=0`, `mem_data_in=0`.
- Write: beat handshake at edge T drives the Memory during T..T+1, and the Memory writes at edge T+1. Back-to-back beats sustain one write per cycle.
- Read: request accept (or previous `rd_ready` handshake) at edge T drives the address from T. `rd_valid` rises after edge T+READ_LATENCY+1 (2 cycles at the default).
- Read throughput: READ_LATENCY+2 cycles per beat with `rd_ready` held high.
- `req_ready` reasserts the cycle after returning to IDLE. No request is accepted on the same edge as the final beat.
- Reset mid-operation: all outputs return to their reset values immediately (asynchronously), with `mem_rw_enable` forced to 1. A partial burst is abandoned, not resumed. Beats already committed stay in memory.

## Test plan
- Single write 0x000←0x1234, single write 0x1FF←0x4321, then single reads of both addresses → `rd_data` 0x1234 then 0x4321, `rd_last=1` on each, `rd_valid` exactly 2 cycles after accept.
- Burst write `req_len=3` at 0x3FE with data 0xA000–0xA003 → writes land at 0x3FE, 0x3FF, 0x000, 0x001; one `wr_done` pulse. Burst read of the same range returns the same data in order, with `rd_last` only on the 4th beat.
- Write burst with `wr_valid` gaps of 0–3 cycles → `mem_rw_enable` is 0 only in cycles following handshakes, and the beat count is exact.
- Read burst with `rd_ready` held low for 5 cycles on beat 2 → `rd_data` is stable throughout, no beat is skipped or duplicated, and `mem_address` does not advance.
- `rst_n` pulsed low during beat 3 of an 8-beat write → outputs reach reset values without waiting for `clk`, and `mem_rw_enable=1`. The next request operates normally, and beats 1–2 remain in memory.
- Idle for 20 cycles with random `wr_valid`/`wr_data`/`rd_ready` → `mem_rw_enable` stays 1 and memory contents are unchanged.

Source files
------------

// File: rtl/mem_port_master.sv
// mem_port_master: exclusive initiator for a single-port synchronous Memory.
// It accepts single or burst read/write requests over a valid/ready handshake,
// drives the Memory rw_enable/address/data_in port, and returns read data per beat.
//
// Ports
//   clk, rst_n                    clock; asynchronous active-low reset
//   req_valid/req_ready           request handshake
//   req_write/req_addr/req_len    request direction, first address, beats minus one
//   wr_valid/wr_ready/wr_data     write beat handshake and data
//   wr_done                       one-cycle pulse when the last write beat commits
//   rd_valid/rd_ready/rd_data     read beat handshake and data
//   rd_last                       marks the final read beat
//   busy                          high whenever the FSM is not idle
//   mem_rw_enable                 to Memory: 0 = write, 1 = read
//   mem_address/mem_data_in       to Memory
//   mem_data_out                  from Memory
module mem_port_master #(
  parameter int unsigned ADDR_W       = 10,
  parameter int unsigned DATA_W       = 16,
  parameter int unsigned LEN_W        = 4,
  parameter int unsigned READ_LATENCY = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [LEN_W-1:0]  req_len,
  input  logic              wr_valid,
  output logic              wr_ready,
  input  logic [DATA_W-1:0] wr_data,
  output logic              wr_done,
  output logic              rd_valid,
  input  logic              rd_ready,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_last,
  output logic              busy,
  output logic              mem_rw_enable,
  output logic [ADDR_W-1:0] mem_address,
  output logic [DATA_W-1:0] mem_data_in,
  input  logic [DATA_W-1:0] mem_data_out
);

  localparam int unsigned LAT_W = (READ_LATENCY < 1) ? 1 : $clog2(READ_LATENCY + 1);

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_WR       = 2'd1,
    S_RD_ISSUE = 2'd2,
    S_RD_RESP  = 2'd3
  } state_t;

  state_t              r_state,         w_state_nxt;
  logic [ADDR_W-1:0]   r_cur_addr,      w_cur_addr_nxt;
  logic [LEN_W-1:0]    r_beats,         w_beats_nxt;
  logic [LAT_W-1:0]    r_lat_cnt,       w_lat_cnt_nxt;
  logic                r_req_ready,     w_req_ready_nxt;
  logic                r_wr_ready,      w_wr_ready_nxt;
  logic                r_wr_done,       w_wr_done_nxt;
  logic                r_rd_valid,      w_rd_valid_nxt;
  logic                r_rd_last,       w_rd_last_nxt;
  logic [DATA_W-1:0]   r_rd_data,       w_rd_data_nxt;
  logic                r_busy,          w_busy_nxt;
  logic                r_mem_rw_enable, w_mem_rw_enable_nxt;
  logic [ADDR_W-1:0]   r_mem_address,   w_mem_address_nxt;
  logic [DATA_W-1:0]   r_mem_data_in,   w_mem_data_in_nxt;

  logic w_wr_hs;
  logic w_rd_hs;

  assign w_wr_hs = wr_valid && r_wr_ready;
  assign w_rd_hs = rd_ready && r_rd_valid;

  // State and registered outputs; reset forces the port back to a safe read.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state         <= S_IDLE;
      r_cur_addr      <= '0;
      r_beats         <= '0;
      r_lat_cnt       <= '0;
      r_req_ready     <= 1'b1;
      r_wr_ready      <= 1'b0;
      r_wr_done       <= 1'b0;
      r_rd_valid      <= 1'b0;
      r_rd_last       <= 1'b0;
      r_rd_data       <= '0;
      r_busy          <= 1'b0;
      r_mem_rw_enable <= 1'b1;
      r_mem_address   <= '0;
      r_mem_data_in   <= '0;
    end else begin
      r_state         <= w_state_nxt;
      r_cur_addr      <= w_cur_addr_nxt;
      r_beats         <= w_beats_nxt;
      r_lat_cnt       <= w_lat_cnt_nxt;
      r_req_ready     <= w_req_ready_nxt;
      r_wr_ready      <= w_wr_ready_nxt;
      r_wr_done       <= w_wr_done_nxt;
      r_rd_valid      <= w_rd_valid_nxt;
      r_rd_last       <= w_rd_last_nxt;
      r_rd_data       <= w_rd_data_nxt;
      r_busy          <= w_busy_nxt;
      r_mem_rw_enable <= w_mem_rw_enable_nxt;
      r_mem_address   <= w_mem_address_nxt;
      r_mem_data_in   <= w_mem_data_in_nxt;
    end
  end

  // Next state and next register values.
  always_comb begin
    w_state_nxt         = r_state;
    w_cur_addr_nxt      = r_cur_addr;
    w_beats_nxt         = r_beats;
    w_lat_cnt_nxt       = r_lat_cnt;
    w_req_ready_nxt     = r_req_ready;
    w_wr_ready_nxt      = r_wr_ready;
    w_wr_done_nxt       = 1'b0;
    w_rd_valid_nxt      = r_rd_valid;
    w_rd_last_nxt       = r_rd_last;
    w_rd_data_nxt       = r_rd_data;
    w_mem_rw_enable_nxt = 1'b1;  // any cycle without an accepted write beat is a read
    w_mem_address_nxt   = r_mem_address;
    w_mem_data_in_nxt   = r_mem_data_in;

    unique case (r_state)
      S_IDLE: begin
        if (req_valid && r_req_ready) begin
          w_cur_addr_nxt  = req_addr;
          w_beats_nxt     = req_len;
          w_req_ready_nxt = 1'b0;
          if (req_write) begin
            w_state_nxt    = S_WR;
            w_wr_ready_nxt = 1'b1;
          end else begin
            w_state_nxt       = S_RD_ISSUE;
            w_mem_address_nxt = req_addr;
            w_lat_cnt_nxt     = '0;
          end
        end
      end

      S_WR: begin
        if (w_wr_hs) begin
          w_mem_address_nxt   = r_cur_addr;
          w_mem_data_in_nxt   = wr_data;
          w_mem_rw_enable_nxt = 1'b0;
          w_cur_addr_nxt      = r_cur_addr + ADDR_W'(1);
          if (r_beats == '0) begin
            w_state_nxt     = S_IDLE;
            w_wr_ready_nxt  = 1'b0;
            w_wr_done_nxt   = 1'b1;
            w_req_ready_nxt = 1'b1;
          end else begin
            w_beats_nxt = r_beats - LEN_W'(1);
          end
        end
      end

      S_RD_ISSUE: begin
        // Address was presented on entry; wait out the Memory latency plus one edge.
        if (r_lat_cnt == LAT_W'(READ_LATENCY)) begin
          w_rd_data_nxt  = mem_data_out;
          w_rd_valid_nxt = 1'b1;
          w_rd_last_nxt  = (r_beats == '0);
          w_state_nxt    = S_RD_RESP;
        end else begin
          w_lat_cnt_nxt = r_lat_cnt + LAT_W'(1);
        end
      end

      S_RD_RESP: begin
        if (w_rd_hs) begin
          w_rd_valid_nxt = 1'b0;
          w_rd_last_nxt  = 1'b0;
          if (r_beats == '0) begin
            w_state_nxt     = S_IDLE;
            w_req_ready_nxt = 1'b1;
          end else begin
            w_beats_nxt       = r_beats - LEN_W'(1);
            w_cur_addr_nxt    = r_cur_addr + ADDR_W'(1);
            w_mem_address_nxt = r_cur_addr + ADDR_W'(1);
            w_lat_cnt_nxt     = '0;
            w_state_nxt       = S_RD_ISSUE;
          end
        end
      end

      default: begin
        w_state_nxt     = S_IDLE;
        w_req_ready_nxt = 1'b1;
        w_wr_ready_nxt  = 1'b0;
        w_rd_valid_nxt  = 1'b0;
        w_rd_last_nxt   = 1'b0;
      end
    endcase

    w_busy_nxt = (w_state_nxt != S_IDLE);
  end

  assign req_ready     = r_req_ready;
  assign wr_ready      = r_wr_ready;
  assign wr_done       = r_wr_done;
  assign rd_valid      = r_rd_valid;
  assign rd_last       = r_rd_last;
  assign rd_data       = r_rd_data;
  assign busy          = r_busy;
  assign mem_rw_enable = r_mem_rw_enable;
  assign mem_address   = r_mem_address;
  assign mem_data_in   = r_mem_data_in;

endmodule

// File: tb/tb_mem_port_master.sv
// Directed testbench for mem_port_master with a behavioural single-port Memory.
module tb_mem_port_master;

  localparam int unsigned ADDR_W = 10;
  localparam int unsigned DATA_W = 16;
  localparam int unsigned LEN_W  = 4;
  localparam int unsigned RL     = 1;

  logic              clk;
  logic              rst_n;
  logic              req_valid;
  logic              req_ready;
  logic              req_write;
  logic [ADDR_W-1:0] req_addr;
  logic [LEN_W-1:0]  req_len;
  logic              wr_valid;
  logic              wr_ready;
  logic [DATA_W-1:0] wr_data;
  logic              wr_done;
  logic              rd_valid;
  logic              rd_ready;
  logic [DATA_W-1:0] rd_data;
  logic              rd_last;
  logic              busy;
  logic              mem_rw_enable;
  logic [ADDR_W-1:0] mem_address;
  logic [DATA_W-1:0] mem_data_in;
  logic [DATA_W-1:0] mem_data_out;

  int n_checks = 0;
  int n_errors = 0;
  int n_writes = 0;
  int n_done   = 0;

  logic [DATA_W-1:0] mem [0:(1<<ADDR_W)-1];
  logic [DATA_W-1:0] exp_tab [0:15];
  int                gap_tab [0:15];

  mem_port_master #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .LEN_W(LEN_W), .READ_LATENCY(RL)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_len(req_len),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_data(wr_data), .wr_done(wr_done),
    .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_data(rd_data), .rd_last(rd_last),
    .busy(busy),
    .mem_rw_enable(mem_rw_enable), .mem_address(mem_address),
    .mem_data_in(mem_data_in), .mem_data_out(mem_data_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Single-port synchronous Memory, one-cycle read latency.
  always @(posedge clk) begin
    if (!mem_rw_enable) mem[mem_address] <= mem_data_in;
    mem_data_out <= mem[mem_address];
  end

  // Count write strobes and wr_done pulses seen by the Memory side.
  always @(posedge clk) begin
    if (rst_n && !mem_rw_enable) n_writes <= n_writes + 1;
    if (rst_n && wr_done) n_done <= n_done + 1;
  end

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s act=%h exp=%h t=%0t", tag, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_req(input logic wr, input logic [ADDR_W-1:0] a, input logic [LEN_W-1:0] l);
    int n;
    n = 0;
    while (!req_ready && n < 50) begin
      tick();
      n++;
    end
    if (!req_ready) check("req_ready_timeout", 32'(req_ready), 32'd1);
    req_valid = 1'b1;
    req_write = wr;
    req_addr  = a;
    req_len   = l;
    tick();
    req_valid = 1'b0;
    check("busy_after_accept", 32'(busy), 32'd1);
  endtask

  task automatic do_write(input logic [ADDR_W-1:0] a, input logic [LEN_W-1:0] l,
                          input logic [DATA_W-1:0] base, input bit use_gaps);
    int w0;
    int d0;
    w0 = n_writes;
    d0 = n_done;
    start_req(1'b1, a, l);
    for (int i = 0; i <= int'(l); i++) begin
      logic [ADDR_W-1:0] ea;
      logic [DATA_W-1:0] ed;
      int g;
      ea = a + ADDR_W'(i);
      ed = base + DATA_W'(i);
      g  = use_gaps ? gap_tab[i] : 0;
      for (int k = 0; k < g; k++) begin
        tick();
        check("gap_we", 32'(mem_rw_enable), 32'd1);
      end
      check("wr_ready", 32'(wr_ready), 32'd1);
      wr_valid = 1'b1;
      wr_data  = ed;
      tick();
      wr_valid = 1'b0;
      check("wr_we", 32'(mem_rw_enable), 32'd0);
      check("wr_addr", 32'(mem_address), 32'(ea));
      check("wr_data", 32'(mem_data_in), 32'(ed));
      check("wr_done", 32'(wr_done), 32'(i == int'(l)));
    end
    tick();
    check("we_after_burst", 32'(mem_rw_enable), 32'd1);
    check("wr_done_clear", 32'(wr_done), 32'd0);
    check("busy_idle_wr", 32'(busy), 32'd0);
    check("write_count", 32'(n_writes - w0), 32'(int'(l) + 1));
    check("done_count", 32'(n_done - d0), 32'd1);
  endtask

  task automatic do_read(input logic [ADDR_W-1:0] a, input logic [LEN_W-1:0] l,
                         input int stall_beat, input int stall_n);
    start_req(1'b0, a, l);
    for (int i = 0; i <= int'(l); i++) begin
      logic [ADDR_W-1:0] ea;
      ea = a + ADDR_W'(i);
      check("rd_addr", 32'(mem_address), 32'(ea));
      check("rd_we", 32'(mem_rw_enable), 32'd1);
      for (int k = 1; k <= int'(RL) + 1; k++) begin
        tick();
        check("rd_valid_lat", 32'(rd_valid), 32'(k == int'(RL) + 1));
      end
      check("rd_data", 32'(rd_data), 32'(exp_tab[i]));
      check("rd_last", 32'(rd_last), 32'(i == int'(l)));
      if (i == stall_beat) begin
        for (int s = 0; s < stall_n; s++) begin
          tick();
          check("stall_valid", 32'(rd_valid), 32'd1);
          check("stall_data", 32'(rd_data), 32'(exp_tab[i]));
          check("stall_addr", 32'(mem_address), 32'(ea));
        end
      end
      rd_ready = 1'b1;
      tick();
      rd_ready = 1'b0;
      check("rd_valid_clear", 32'(rd_valid), 32'd0);
    end
    check("busy_idle_rd", 32'(busy), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog_timeout t=%0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    int w0;
    rst_n     = 1'b0;
    req_valid = 1'b0;
    req_write = 1'b0;
    req_addr  = '0;
    req_len   = '0;
    wr_valid  = 1'b0;
    wr_data   = '0;
    rd_ready  = 1'b0;
    for (int i = 0; i < (1 << ADDR_W); i++) mem[i] = '0;

    // Reset values
    #12;
    check("rst_req_ready", 32'(req_ready), 32'd1);
    check("rst_wr_ready", 32'(wr_ready), 32'd0);
    check("rst_rd_valid", 32'(rd_valid), 32'd0);
    check("rst_rd_last", 32'(rd_last), 32'd0);
    check("rst_rd_data", 32'(rd_data), 32'd0);
    check("rst_wr_done", 32'(wr_done), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_we", 32'(mem_rw_enable), 32'd1);
    check("rst_addr", 32'(mem_address), 32'd0);
    check("rst_din", 32'(mem_data_in), 32'd0);
    #11 rst_n = 1'b1;
    tick();

    // Single writes then single reads
    do_write(10'h000, 4'd0, 16'h1234, 1'b0);
    do_write(10'h1FF, 4'd0, 16'h4321, 1'b0);
    exp_tab[0] = 16'h1234;
    do_read(10'h000, 4'd0, -1, 0);
    exp_tab[0] = 16'h4321;
    do_read(10'h1FF, 4'd0, -1, 0);

    // Burst write across the address wrap, then read back
    do_write(10'h3FE, 4'd3, 16'hA000, 1'b0);
    check("mem_3fe", 32'(mem[10'h3FE]), 32'h0000A000);
    check("mem_3ff", 32'(mem[10'h3FF]), 32'h0000A001);
    check("mem_000", 32'(mem[10'h000]), 32'h0000A002);
    check("mem_001", 32'(mem[10'h001]), 32'h0000A003);
    check("mem_1ff", 32'(mem[10'h1FF]), 32'h00004321);
    for (int i = 0; i < 4; i++) exp_tab[i] = 16'hA000 + 16'(i);
    do_read(10'h3FE, 4'd3, -1, 0);

    // Write burst with wr_valid gaps
    gap_tab[0] = 0; gap_tab[1] = 1; gap_tab[2] = 2;
    gap_tab[3] = 3; gap_tab[4] = 0; gap_tab[5] = 2;
    do_write(10'h040, 4'd5, 16'hC000, 1'b1);
    for (int i = 0; i < 6; i++) exp_tab[i] = 16'hC000 + 16'(i);
    do_read(10'h040, 4'd5, -1, 0);

    // Read burst with a 5-cycle consumer stall on beat 2
    for (int i = 0; i < 4; i++) exp_tab[i] = 16'hA000 + 16'(i);
    do_read(10'h3FE, 4'd3, 1, 5);

    // Asynchronous reset during beat 3 of an 8-beat write
    start_req(1'b1, 10'h100, 4'd7);
    for (int i = 0; i < 2; i++) begin
      wr_valid = 1'b1;
      wr_data  = 16'hB000 + 16'(i);
      tick();
    end
    wr_data = 16'hB002;
    tick();
    wr_valid = 1'b0;
    check("pre_rst_we", 32'(mem_rw_enable), 32'd0);
    #3 rst_n = 1'b0;
    #1;
    check("arst_we", 32'(mem_rw_enable), 32'd1);
    check("arst_busy", 32'(busy), 32'd0);
    check("arst_wr_ready", 32'(wr_ready), 32'd0);
    check("arst_req_ready", 32'(req_ready), 32'd1);
    check("arst_addr", 32'(mem_address), 32'd0);
    check("arst_din", 32'(mem_data_in), 32'd0);
    #2 rst_n = 1'b1;
    tick();
    check("mem_100", 32'(mem[10'h100]), 32'h0000B000);
    check("mem_101", 32'(mem[10'h101]), 32'h0000B001);
    exp_tab[0] = 16'hB000;
    exp_tab[1] = 16'hB001;
    do_read(10'h100, 4'd1, -1, 0);
    do_write(10'h200, 4'd1, 16'hD000, 1'b0);
    check("mem_201", 32'(mem[10'h201]), 32'h0000D001);

    // Idle with random noise on the beat interfaces
    w0 = n_writes;
    for (int i = 0; i < 20; i++) begin
      wr_valid = 1'($urandom_range(0, 1));
      wr_data  = 16'($urandom);
      rd_ready = 1'($urandom_range(0, 1));
      tick();
      check("idle_we", 32'(mem_rw_enable), 32'd1);
    end
    wr_valid = 1'b0;
    rd_ready = 1'b0;
    tick();
    check("idle_writes", 32'(n_writes - w0), 32'd0);
    check("idle_busy", 32'(busy), 32'd0);
    check("idle_mem_040", 32'(mem[10'h040]), 32'h0000C000);
    check("idle_mem_200", 32'(mem[10'h200]), 32'h0000D000);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
